pack_telemetry: RTL and testbench



---
 rtl/pack_telemetry.sv | 181 ++++++++++++++++++
 tb/tb_pack_telemetry.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pack_telemetry.sv
// rtl/pack_telemetry.sv - telemetry word framer onto the 8b10b encoder byte interface
//
// Purpose:
//   Accepts 11-byte telemetry words through a one-deep holding buffer. Each word
//   is serialised as one K character followed by 11 data bytes, LSB byte first.
//   Idle K characters fill the gaps between frames. The idle K also serves as
//   the frame start, so back-to-back words cost exactly 12 symbols each.
//
// Ports:
//   clk        in   link byte clock
//   rst        in   synchronous active-high reset
//   tlm_data   in   telemetry word, byte n = bits [8n+7:8n]
//   tlm_valid  in   word offered this cycle
//   tlm_ready  out  holding buffer empty (registered)
//   tx_en      in   encoder symbol request strobe
//   k_out      out  current symbol is a K character
//   data_out   out  current symbol byte
//   valid_out  out  tx_en delayed by one cycle
//   overflow   out  one-cycle pulse for a word dropped while the buffer was full

module pack_telemetry #(
  parameter int         g_data_width = 11,
  parameter logic [7:0] g_k_char     = 8'hBC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [g_data_width*8-1:0] tlm_data,
  input  logic                      tlm_valid,
  output logic                      tlm_ready,
  input  logic                      tx_en,
  output logic                      k_out,
  output logic [7:0]                data_out,
  output logic                      valid_out,
  output logic                      overflow
);

  // The 4-bit byte index and the frame length only work out for 11 bytes.
  if (g_data_width != 11) begin : g_width_check
    $fatal(1, "pack_telemetry: g_data_width must be 11");
  end

  localparam int         WordBits = g_data_width * 8;
  localparam logic [3:0] IdxLast  = 4'(g_data_width - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                buf_full_q, buf_full_d;
  logic [WordBits-1:0] buf_q, buf_d;
  logic [WordBits-1:0] shift_q, shift_d;
  logic [3:0]          idx_q, idx_d;
  logic                k_q, k_d;
  logic [7:0]          data_q, data_d;
  logic                valid_q, valid_d;
  logic                ovf_q, ovf_d;

  // Symbol chosen by the FSM for the current cycle (registered on tx_en).
  logic                sym_k;
  logic [7:0]          sym_data;
  logic                load;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. Only tx_en cycles advance; a started frame always runs
  // to byte 10 before returning to IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (tx_en) begin
      case (state_q)
        ST_IDLE: if (buf_full_q) state_d = ST_DATA;
        ST_DATA: if (idx_q == IdxLast) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. IDLE always sends K, including the frame-start K issued in
  // the same symbol slot that moves the buffer into the shift register.
  // ---------------------------------------------------------------------------
  always_comb begin
    sym_k    = 1'b1;
    sym_data = g_k_char;
    load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sym_k    = 1'b1;
        sym_data = g_k_char;
        load     = tx_en & buf_full_q;
      end
      ST_DATA: begin
        sym_k    = 1'b0;
        sym_data = shift_q[{idx_q, 3'b000} +: 8];
      end
      default: begin
        sym_k    = 1'b1;
        sym_data = g_k_char;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    buf_full_d = buf_full_q;
    buf_d      = buf_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    k_d        = k_q;
    data_d     = data_q;
    valid_d    = tx_en;
    // A word offered into a full buffer is lost; the buffer keeps its word.
    ovf_d      = tlm_valid & buf_full_q;

    // Transfer needs buf_full=1 and accept needs buf_full=0, so the two
    // updates below never act in the same cycle.
    if (load) begin
      shift_d    = buf_q;
      buf_full_d = 1'b0;
      idx_d      = 4'd0;
    end
    if (tlm_valid && !buf_full_q) begin
      buf_d      = tlm_data;
      buf_full_d = 1'b1;
    end

    if (tx_en && state_q == ST_DATA) begin
      idx_d = (idx_q == IdxLast) ? 4'd0 : idx_q + 4'd1;
    end

    // Symbol outputs hold their last value on cycles without a request.
    if (tx_en) begin
      k_d    = sym_k;
      data_d = sym_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      shift_q    <= '0;
      idx_q      <= 4'd0;
      k_q        <= 1'b0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      buf_full_q <= buf_full_d;
      buf_q      <= buf_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      k_q        <= k_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign tlm_ready = ~buf_full_q;
  assign k_out     = k_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pack_telemetry.sv
// tb/tb_pack_telemetry.sv - self-checking bench for pack_telemetry

module tb_pack_telemetry;

  localparam logic [7:0] KCHAR = 8'hBC;

  logic        clk;
  logic        rst;
  logic [87:0] tlm_data;
  logic        tlm_valid;
  logic        tlm_ready;
  logic        tx_en;
  logic        k_out;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        overflow;

  pack_telemetry #(.g_data_width(11), .g_k_char(KCHAR)) dut (
    .clk       (clk),
    .rst       (rst),
    .tlm_data  (tlm_data),
    .tlm_valid (tlm_valid),
    .tlm_ready (tlm_ready),
    .tx_en     (tx_en),
    .k_out     (k_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a one-slot buffer and a queue of symbols still owed for
  // the frame currently on the wire. An empty queue means the link is idle.
  logic        m_buf_full;
  logic [87:0] m_buf;
  logic [8:0]  m_frame[$];
  logic        exp_k;
  logic [7:0]  exp_data;
  logic        exp_valid;
  logic        exp_ovf;
  logic        exp_ready;

  // Receive-side unpacker over the DUT output stream.
  logic [87:0] rx_word;
  int          rx_cnt;
  logic        rx_in_frame;
  logic [87:0] rx_q[$];
  int          ovf_seen;

  logic [11:0] obs;
  logic [11:0] expv;

  task automatic cycle(input logic r, input logic v, input logic [87:0] d, input logic en);
    logic bf0;
    logic [8:0] sym;
    rst       = r;
    tlm_valid = v;
    tlm_data  = d;
    tx_en     = en;
    if (r) begin
      m_buf_full = 1'b0;
      m_frame.delete();
      exp_k = 1'b0; exp_data = 8'h00; exp_valid = 1'b0; exp_ovf = 1'b0;
    end else begin
      bf0       = m_buf_full;
      exp_valid = en;
      exp_ovf   = v & bf0;
      if (en) begin
        if (m_frame.size() == 0 && bf0) begin
          m_frame.push_back({1'b1, KCHAR});
          for (int i = 0; i < 11; i++) m_frame.push_back({1'b0, m_buf[8*i +: 8]});
          m_buf_full = 1'b0;
        end
        if (m_frame.size() != 0) sym = m_frame.pop_front();
        else sym = {1'b1, KCHAR};
        exp_k    = sym[8];
        exp_data = sym[7:0];
      end
      if (v && !bf0) begin
        m_buf      = d;
        m_buf_full = 1'b1;
      end
    end
    exp_ready = ~m_buf_full;
    @(posedge clk);
    #1;
    obs  = {valid_out, k_out, data_out, tlm_ready, overflow};
    expv = {exp_valid, exp_k, exp_data, exp_ready, exp_ovf};
    if (r) begin
      rx_in_frame = 1'b0;
      rx_cnt      = 0;
    end else begin
      if (overflow) ovf_seen++;
      if (valid_out) begin
        if (k_out) begin
          rx_in_frame = 1'b1;
          rx_cnt      = 0;
        end else if (rx_in_frame) begin
          rx_word[8*rx_cnt +: 8] = data_out;
          rx_cnt++;
          if (rx_cnt == 11) begin
            rx_q.push_back(rx_word);
            rx_in_frame = 1'b0;
          end
        end
      end
    end
  endtask

  function automatic logic [87:0] rand_word();
    logic [87:0] w;
    w = {$urandom(), $urandom(), $urandom()};
    return w;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b1);
      n_total++;
      if (obs !== 12'b0_0_00000000_1_0) $display("FAIL reset_state cyc %0d got %h want %h", i, obs, 12'b0_0_00000000_1_0);
      else n_pass++;
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b1);
      n_total++;
      if (obs !== expv || obs !== {1'b1, 1'b1, KCHAR, 1'b1, 1'b0}) $display("FAIL idle_k cyc %0d got %h want %h", i, obs, expv);
      else n_pass++;
    end
  endtask

  task automatic test_single();
    logic [87:0] w;
    w = 88'h0A09_0807_0605_0403_0201_00;
    rx_q.delete();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, i == 0, w, 1'b1);
      n_total++;
      if (obs !== expv) $display("FAIL single_sym cyc %0d got %h want %h", i, obs, expv);
      else n_pass++;
    end
    n_total++;
    if (rx_q.size() != 1 || rx_q[0] !== w) $display("FAIL single_rx got n=%0d w=%h want n=1 w=%h", rx_q.size(), (rx_q.size() != 0) ? rx_q[0] : 88'h0, w);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [87:0] words[3];
    int sent;
    logic v;
    sent = 0;
    ovf_seen = 0;
    rx_q.delete();
    for (int i = 0; i < 3; i++) words[i] = rand_word();
    for (int i = 0; i < 45; i++) begin
      v = !m_buf_full && sent < 3;
      cycle(1'b0, v, words[(sent < 3) ? sent : 2], 1'b1);
      if (v) sent++;
      n_total++;
      if (obs !== expv) $display("FAIL b2b_sym cyc %0d got %h want %h", i, obs, expv);
      else n_pass++;
    end
    n_total++;
    if (ovf_seen != 0) $display("FAIL b2b_overflow got %0d want 0", ovf_seen);
    else n_pass++;
    n_total++;
    if (rx_q.size() != 3) $display("FAIL b2b_count got %0d want 3", rx_q.size());
    else n_pass++;
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      n_total++;
      if (rx_q[i] !== words[i]) $display("FAIL b2b_word %0d got %h want %h", i, rx_q[i], words[i]);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    logic [87:0] a;
    ovf_seen = 0;
    rx_q.delete();
    a = rand_word();
    a[8*5 +: 8] = KCHAR;
    a[8*10 +: 8] = KCHAR;
    cycle(1'b0, 1'b1, a, 1'b0);
    cycle(1'b0, 1'b1, rand_word(), 1'b0);
    n_total++;
    if (obs !== expv) $display("FAIL ovf_b got %h want %h", obs, expv);
    else n_pass++;
    cycle(1'b0, 1'b1, rand_word(), 1'b0);
    n_total++;
    if (obs !== expv) $display("FAIL ovf_c got %h want %h", obs, expv);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b1);
      n_total++;
      if (obs !== expv) $display("FAIL ovf_sym cyc %0d got %h want %h", i, obs, expv);
      else n_pass++;
    end
    n_total++;
    if (ovf_seen != 2) $display("FAIL ovf_pulses got %0d want 2", ovf_seen);
    else n_pass++;
    n_total++;
    if (rx_q.size() != 1 || rx_q[0] !== a) $display("FAIL ovf_rx got n=%0d want n=1 w=%h", rx_q.size(), a);
    else n_pass++;
  endtask

  task automatic test_gapped();
    logic [87:0] w;
    w = 88'h0A09_0807_0605_0403_0201_00;
    rx_q.delete();
    for (int i = 0; i < 45; i++) begin
      cycle(1'b0, i == 1, w, (i % 3) == 0);
      n_total++;
      if (obs !== expv) $display("FAIL gap_sym cyc %0d got %h want %h", i, obs, expv);
      else n_pass++;
    end
    n_total++;
    if (rx_q.size() != 1 || rx_q[0] !== w) $display("FAIL gap_rx got n=%0d want n=1 w=%h", rx_q.size(), w);
    else n_pass++;
  endtask

  task automatic test_rst_mid();
    logic [87:0] w1;
    logic [87:0] w2;
    w1 = rand_word();
    w2 = rand_word();
    rx_q.delete();
    for (int i = 0; i < 7; i++) cycle(1'b0, i == 0, w1, 1'b1);
    n_total++;
    if (k_out !== 1'b0 || data_out !== w1[8*4 +: 8]) $display("FAIL rst_mid_byte4 got k=%b d=%h want k=0 d=%h", k_out, data_out, w1[8*4 +: 8]);
    else n_pass++;
    cycle(1'b1, 1'b0, '0, 1'b1);
    n_total++;
    if (obs !== 12'b0_0_00000000_1_0) $display("FAIL rst_mid_state got %h want %h", obs, 12'b0_0_00000000_1_0);
    else n_pass++;
    cycle(1'b0, 1'b0, '0, 1'b1);
    n_total++;
    if (k_out !== 1'b1 || data_out !== KCHAR || obs !== expv) $display("FAIL rst_mid_first_k got %h want %h", obs, expv);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, i == 0, w2, 1'b1);
      n_total++;
      if (obs !== expv) $display("FAIL rst_mid_sym cyc %0d got %h want %h", i, obs, expv);
      else n_pass++;
    end
    n_total++;
    if (rx_q.size() != 1 || rx_q[0] !== w2) $display("FAIL rst_mid_rx got n=%0d want n=1 w=%h", rx_q.size(), w2);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; tlm_valid = 1'b0; tlm_data = '0; tx_en = 1'b0;
    m_buf_full = 1'b0; m_buf = '0;
    exp_k = 1'b0; exp_data = 8'h00; exp_valid = 1'b0; exp_ovf = 1'b0; exp_ready = 1'b1;
    rx_word = '0; rx_cnt = 0; rx_in_frame = 1'b0; ovf_seen = 0;
    obs = '0; expv = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_gapped();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
